// File: rtl/lsu_dmem_port.sv
// rtl/lsu_dmem_port.sv - RV32 load/store unit driving a word-wide req/gnt/rvalid data memory port (optional macro LSU_MISALIGN_TRAP_EN)
module lsu_dmem_port #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     store_data,
    output logic                      ex_ready,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      misalign_err,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH/8-1:0]   dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Captured access context; held stable for the whole access.
    logic                    r_we;
    logic [FUNCT3_WIDTH-1:0] r_funct3;
    logic [1:0]              r_off;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [BE_W-1:0]         r_be;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    logic                    w_accept;
    logic                    w_is_byte;
    logic                    w_is_half;
    logic                    w_is_word;
    logic                    w_trap;
    logic [1:0]              w_off;
    logic [BE_W-1:0]         w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;

    // Access size decode; 100/101 only mean byte/half for loads, every other code is a word.
    assign w_accept  = (r_state == S_IDLE) && ex_valid && (mem_read || mem_write);
    assign w_is_byte = (funct3 == 3'b000) || (!mem_write && (funct3 == 3'b100));
    assign w_is_half = (funct3 == 3'b001) || (!mem_write && (funct3 == 3'b101));
    assign w_is_word = !w_is_byte && !w_is_half;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    // A misaligned access skips memory entirely and reports through misalign_err.
    assign w_misalign = (w_is_half && ALUResult[0]) || (w_is_word && (ALUResult[1:0] != 2'b00));
    assign w_trap     = w_misalign;
    assign w_off      = ALUResult[1:0];

    // Error flag is set on the accepting edge so it coincides with the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_trap;
        end
    end

    assign misalign_err = r_misalign;
`else
    // Without trapping, low address bits are silently forced to natural alignment.
    assign w_trap       = 1'b0;
    assign w_off        = w_is_word ? 2'b00 :
                          w_is_half ? {ALUResult[1], 1'b0} : ALUResult[1:0];
    assign misalign_err = 1'b0;
`endif

    // Lane enables and lane-replicated write data for the request being accepted.
    always_comb begin
        w_be    = {BE_W{1'b1}};
        w_wdata = store_data;
        if (mem_write) begin
            if (w_is_byte) begin
                w_be    = {{(BE_W-1){1'b0}}, 1'b1} << w_off;
                w_wdata = {BE_W{store_data[7:0]}};
            end else if (w_is_half) begin
                w_be    = {{(BE_W-2){1'b0}}, 2'b11} << {w_off[1], 1'b0};
                w_wdata = {(BE_W/2){store_data[15:0]}};
            end
        end
    end

    // Load lane extraction and sign/zero extension from the returned word.
    assign w_shifted = dmem_rdata >> {r_off, 3'b000};
    assign w_half    = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load = dmem_rdata;
        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> REQ (or straight to DONE on a trapped access) -> WAIT for loads -> DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_trap ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    w_next = r_we ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture request context on accept and load results on rvalid; rd_data is untouched by stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_off     <= 2'b00;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= mem_write;
                r_funct3 <= funct3;
                r_off    <= w_off;
                r_addr   <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_wdata;
            end
            if ((r_state == S_WAIT) && dmem_rvalid) begin
                r_rd_data <= w_load;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign ex_ready   = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign dmem_req   = (r_state == S_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// tb/tb_lsu_dmem_port.sv - self-checking bench for lsu_dmem_port against a behavioural access model
module tb_lsu_dmem_port;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, store_data;
    logic        ex_ready, busy, done, misalign_err;
    logic [31:0] rd_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    lsu_dmem_port #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .ALUResult(ALUResult),
        .store_data(store_data), .ex_ready(ex_ready), .busy(busy), .done(done),
        .rd_data(rd_data), .misalign_err(misalign_err), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle, set by the stimulus process.
    bit          chk_en = 1'b0;
    bit          exp_busy, exp_req, exp_done, exp_mis, exp_we;
    logic [31:0] exp_addr, exp_wdata, model_rd;
    logic [3:0]  exp_be;
    bit          lit_on = 1'b0;
    logic [31:0] lit_exp;
    bit          pins_done = 1'b0;
    int          vectors = 0;
    int          fails = 0;

    // Access size in bytes from the opcode rules.
    function automatic int acc_size(input bit st, input logic [2:0] f);
        if (f == 3'b000) return 1;
        if (f == 3'b001) return 2;
        if (!st && f == 3'b100) return 1;
        if (!st && f == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] f, input int off, input logic [31:0] w);
        int          size;
        logic [31:0] v;
        size = acc_size(1'b0, f);
        v = w >> (8 * off);
        if (size == 1) begin
            v = v & 32'h0000_00FF;
            if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] st_be(input int size, input int off);
        if (size == 4) return 4'hF;
        return 4'(((1 << size) - 1) << off);
    endfunction

    function automatic logic [31:0] st_wdata(input int size, input logic [31:0] d);
        logic [31:0] b, h;
        b = {24'h0, d[7:0]};
        h = {16'h0, d[15:0]};
        if (size == 1) return b * 32'h0101_0101;
        if (size == 2) return h * 32'h0001_0001;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Single compare process: every checked cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (!pins_done) begin
            pins_done = 1'b1;
            chk("pin_lb",  ext_load(3'b000, 2, 32'h12F0_3456), 32'hFFFF_FFF0);
            chk("pin_lbu", ext_load(3'b100, 2, 32'h12F0_3456), 32'h0000_00F0);
            chk("pin_lh",  ext_load(3'b001, 2, 32'h8001_5A5A), 32'hFFFF_8001);
            chk("pin_sb_be", {28'h0, st_be(1, 3)}, 32'h0000_0008);
            chk("pin_sb_wd", st_wdata(1, 32'h0000_00A5), 32'hA5A5_A5A5);
        end
        if (chk_en) begin
            chk("busy",     {31'h0, busy},         {31'h0, exp_busy});
            chk("ex_ready", {31'h0, ex_ready},     {31'h0, !exp_busy});
            chk("dmem_req", {31'h0, dmem_req},     {31'h0, exp_req});
            chk("done",     {31'h0, done},         {31'h0, exp_done});
            chk("misalign", {31'h0, misalign_err}, {31'h0, exp_mis});
            chk("rd_data",  rd_data,               model_rd);
            if (exp_req) begin
                chk("dmem_addr", dmem_addr,          exp_addr);
                chk("dmem_be",   {28'h0, dmem_be},   {28'h0, exp_be});
                chk("dmem_we",   {31'h0, dmem_we},   {31'h0, exp_we});
                if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (!rst_n) begin
                chk("rst_addr",  dmem_addr,  32'h0);
                chk("rst_be",    {28'h0, dmem_be}, 32'h0);
                chk("rst_wdata", dmem_wdata, 32'h0);
                chk("rst_we",    {31'h0, dmem_we}, 32'h0);
            end
            if (lit_on) chk("rd_literal", rd_data, lit_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic set_exp(input bit b, input bit r, input bit d, input bit m);
        exp_busy = b;
        exp_req  = r;
        exp_done = d;
        exp_mis  = m;
    endtask

    // One access: gd = cycles gnt is held low, rl = extra cycles between gnt and rvalid.
    task automatic access(input bit wr, input bit rd, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input int gd, input int rl, input logic [31:0] rw);
        int          size, off;
        bit          trap;
        logic [31:0] load_val;
        size = acc_size(wr, f);
        off  = int'(a[1:0]);
        trap = TRAP && ((off % size) != 0);
        if (!trap) off = off - (off % size);
        step();
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f; ALUResult = a; store_data = sd;
        set_exp(0, 0, 0, 0);
        if (!wr && !rd) begin
            step();
            ex_valid = 1'b0;
            set_exp(0, 0, 0, 0);
            return;
        end
        if (trap) begin
            step();
            ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            set_exp(1, 0, 1, 1);
            step();
            set_exp(0, 0, 0, 0);
            return;
        end
        exp_addr  = {a[31:2], 2'b00};
        exp_we    = wr;
        exp_be    = wr ? st_be(size, off) : 4'hF;
        exp_wdata = st_wdata(size, sd);
        for (int k = 0; k <= gd; k++) begin
            step();
            ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            funct3 = 3'($urandom); ALUResult = $urandom; store_data = $urandom;
            dmem_gnt = (k == gd);
            set_exp(1, 1, 0, 0);
        end
        load_val = ext_load(f, off, rw);
        if (!wr) begin
            for (int j = 0; j <= rl; j++) begin
                step();
                dmem_gnt    = 1'b0;
                dmem_rvalid = (j == rl);
                dmem_rdata  = (j == rl) ? rw : $urandom;
                set_exp(1, 0, 0, 0);
            end
        end
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        if (!wr) model_rd = load_val;
        set_exp(1, 0, 1, 0);
        step();
        set_exp(0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        ALUResult = 32'h0; store_data = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0; exp_we = 1'b0;
        lit_exp = 32'h0;
        model_rd = 32'h0;
        set_exp(0, 0, 0, 0);
        chk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // SW 0x100, immediate gnt: done two cycles after accept
        access(1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
        // SB 0x103 with gnt held low three cycles
        access(1, 0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 3, 0, 32'h0);
        // LB / LBU at 0x202
        access(0, 1, 3'b000, 32'h0000_0202, 32'h0, 0, 0, 32'h12F0_3456);
        lit_on = 1'b1; lit_exp = 32'hFFFF_FFF0;
        access(0, 1, 3'b100, 32'h0000_0202, 32'h0, 0, 0, 32'h12F0_3456);
        lit_on = 1'b1; lit_exp = 32'h0000_00F0;
        // LH at 0x206 with gnt and rvalid wait states
        access(0, 1, 3'b001, 32'h0000_0206, 32'h0, 1, 2, 32'h8001_5A5A);
        lit_on = 1'b1; lit_exp = 32'hFFFF_8001;
        // Store must leave rd_data alone
        access(1, 0, 3'b001, 32'h0000_0106, 32'h1234_BEEF, 1, 0, 32'h0);
        lit_on = 1'b1; lit_exp = 32'hFFFF_8001;
        // Misaligned LW (trap or forced alignment)
        access(0, 1, 3'b010, 32'h0000_0301, 32'h0, 0, 1, 32'h1122_3344);
        // Misaligned SH
        access(1, 0, 3'b001, 32'h0000_0105, 32'h0000_C3D2, 0, 0, 32'h0);
        // LHU upper half, reserved funct3 as word load
        access(0, 1, 3'b101, 32'h0000_020A, 32'h0, 2, 0, 32'hFEDC_1234);
        lit_on = 1'b1; lit_exp = 32'h0000_FEDC;
        access(0, 1, 3'b011, 32'h0000_0400, 32'h0, 0, 0, 32'hCAFE_F00D);
        // ex_valid with neither read nor write is ignored
        access(0, 0, 3'b010, 32'h0000_0500, 32'h0, 0, 0, 32'h0);
        // Both read and write: write wins
        access(1, 1, 3'b000, 32'h0000_0601, 32'h0000_0077, 0, 0, 32'h0);

        // Reset asserted during WAIT; late rvalid after release must be ignored
        step();
        ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_0700;
        set_exp(0, 0, 0, 0);
        step();
        ex_valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
        exp_addr = 32'h0000_0700; exp_be = 4'hF; exp_we = 1'b0;
        set_exp(1, 1, 0, 0);
        step();
        dmem_gnt = 1'b0;
        set_exp(1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_rd = 32'h0;
        set_exp(0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        step();
        dmem_rvalid = 1'b0;
        step();
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
- Load/store unit directly downstream of the ALU in the execute stage.
- Takes ALUResult as the effective byte address, plus funct3 and store data.
- Drives a word-wide req/gnt/rvalid data-memory interface.
- Returns sign/zero-extended load data to writeback; holds busy high to stall the pipeline while an access is in flight.

Parameters:
DATA_WIDTH, 32, data and address width (fixed 32 for RV32; byte lanes = DATA_WIDTH/8 = 4)
FUNCT3_WIDTH, 3, width of the funct3 size/sign field

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  execute-stage instruction valid
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
funct3  input  3  access size/sign
ALUResult  input  32  effective byte address
store_data  input  32  rs2 value for stores
ex_ready  output  1  LSU can accept (high only in IDLE)
busy  output  1  access in flight; pipeline stall
done  output  1  one-cycle pulse when an access completes
rd_data  output  32  extended load result
misalign_err  output  1  one-cycle pulse on a misaligned access
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  word address, {addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-aligned write data
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read word

Behaviour:
- Reset: state=IDLE. Reset is asynchronous and may occur mid-access; the access is abandoned with no retry.
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, rd_data=0, done=0, misalign_err=0, busy=0, ex_ready=1.
- FSM states: IDLE, REQ, WAIT, DONE. busy = (state != IDLE); ex_ready = (state == IDLE).
- IDLE:
  - ex_valid & (mem_read|mem_write): register address, funct3, store_data and direction (write wins if both set), then go to REQ.
  - ex_valid with neither read nor write: ignored.
- REQ:
  - dmem_req=1, dmem_addr/dmem_be/dmem_wdata/dmem_we stable until gnt.
  - On dmem_gnt: store goes to DONE; load goes to WAIT.
- WAIT: dmem_rvalid sampled only here (memory gives rvalid at least 1 cycle after gnt). On rvalid: extract lane, extend, load rd_data, go to DONE.
- DONE: done=1 for one cycle, then IDLE. rd_data holds until the next load completes; stores never change it.
- Latency:
  - Store with gnt in its first REQ cycle: accept at cycle 0, req at 1, done at 2.
  - Load with gnt at 1 and rvalid at 2: done at 3.
  - Each wait state adds one cycle.
- Byte enables and write data:
  - SB (000): be = 4'b0001 << a[1:0]; wdata = byte replicated x4.
  - SH (001): be = 4'b0011 << {a[1],1'b0}; wdata = halfword replicated x2.
  - SW (010): be = 4'b1111.
  - Loads drive be = 4'b1111.
- Load extraction:
  - LB 000 / LBU 100: byte at a[1:0], sign- / zero-extended.
  - LH 001 / LHU 101: half at a[1], sign- / zero-extended.
  - LW 010: whole word.
  - Any other funct3 is treated as a word access.
- Misalignment: half access with a[0]=1, or word access with a[1:0]!=0 (handling per macro below).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access at accept pulses misalign_err for one cycle and goes IDLE->DONE with no memory request.
  - done pulses in the DONE cycle; rd_data is unchanged.
- Undefined:
  - misalign_err is tied 0.
  - Low address bits are forced to natural alignment (half: a[0]=0; word: a[1:0]=0) and the access proceeds normally.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, gnt immediate -> dmem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; done at cycle 2.
- SB, addr 0x103, data 0x000000A5, gnt held low 3 cycles -> req/addr/be stable throughout; be 1000, wdata 0xA5A5A5A5; done 1 cycle after gnt.
- LB / LBU at 0x202, rdata 0x12F03456 -> rd_data 0xFFFFFFF0 / 0x000000F0.
- LH at 0x206, rdata 0x8001xxxx -> rd_data 0xFFFF8001; ex_ready low and busy high from accept to DONE.
- LW at 0x301 -> with LSU_MISALIGN_TRAP_EN: misalign_err pulse, no dmem_req. Without it: dmem_addr 0x300, normal load.
- rst_n low during WAIT -> asynchronously state IDLE, dmem_req 0, rd_data 0; a late rvalid after release is ignored.
